ddr3_loopback_tester: RTL
=========================

# ddr3_loopback_tester

Parametrised traffic generator and checker driving the user port of `ddr3_memory_controller`. It writes `NUM_OF_TEST_DATA` words of a selectable pattern to consecutive addresses, then reads them back and compares each word against a regenerated expected value. It reports done, pass/fail, error count and first failing address. It replaces the fixed 4-word incrementing loopback in the top-level test wrapper, and its status outputs feed LEDs and the ILA.

## Interface
- `DQ_BITWIDTH`, 8: data word width.
- `ADDRESS_BITWIDTH`, 15: row/column address width.
- `BANK_ADDRESS_BITWIDTH`, 3: bank address width.
- `NUM_OF_TEST_DATA`, 4: words per pass; ≥1.
- `START_ADDRESS`, 0: first user address, width `BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH`.
- `LFSR_TAPS`, 8'hB8: Galois feedback mask, `DQ_BITWIDTH` bits wide.
- `LFSR_SEED`, 1: LFSR start value; a value of 0 is replaced by 1.
- `ERR_CNT_BITWIDTH`, 8: width of the error and pass counters.

Ports (AW = `BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH`):
- `clk` in 1: single clock; all logic on posedge.
- `resetn` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that begins a pass from IDLE or DONE.
- `abort` in 1: returns to IDLE from any state.
- `pattern_sel` in 2: 0 = incrementing, 1 = LFSR, 2 = walking-ones, 3 = alternating 0x55../0xAA..; latched on accepted `start`.
- `continuous` in 1: latched on accepted `start`; when set, the block restarts automatically after each pass.
- `write_enable` out 1: write request to the controller.
- `read_enable` out 1: read request to the controller.
- `i_user_data_address` out AW: request address.
- `data_to_ram` out DQ_BITWIDTH: write data.
- `write_ack` in 1: controller accepted the current write.
- `read_ack` in 1: controller accepted the current read address.
- `read_valid` in 1: `data_from_ram` is valid; reads return in order.
- `data_from_ram` in DQ_BITWIDTH: read data.
- `busy` out 1: high in WRITE or READ.
- `done` out 1: level, high in DONE.
- `pass` out 1: `done` AND error count == 0.
- `error_count` out ERR_CNT_BITWIDTH: number of mismatches; saturates at all-ones.
- `first_error_address` out AW: address of the first mismatch in the current pass.
- `pass_count` out ERR_CNT_BITWIDTH: completed passes; wraps.

## Operation
- States are IDLE, WRITE, READ and DONE.
- IDLE → WRITE on `start`. Entering WRITE does the following:
  - Clears the issue, ack and check counters.
  - Clears `error_count` and `first_error_address`.
  - Loads the generators and latches the mode.
- Pattern for word index k (the write and check generators are separate, identical instances):
  - inc: `k` mod 2^DQ_BITWIDTH.
  - LFSR: word 0 = seed; next = (d>>1) ^ (d[0] ? `LFSR_TAPS` : 0).
  - walking-ones: `1 << (k mod DQ_BITWIDTH)`.
  - alternating: 0x55.. for even k, 0xAA.. for odd k.
- WRITE:
  - `write_enable` = 1; address = `START_ADDRESS + k`, wrapping modulo 2^AW.
  - On `write_ack`, k and the write generator advance.
  - After the `NUM_OF_TEST_DATA`-th ack, the block moves to READ.
- READ:
  - `read_enable` = 1 until `NUM_OF_TEST_DATA` `read_ack`s have been received; the address advances per ack.
  - Independently, each `read_valid` compares `data_from_ram` with the check generator and then advances it.
  - On a mismatch, `error_count` increments (saturating). On the first mismatch of a pass only, `first_error_address` = `START_ADDRESS` + check index.
  - The block goes to DONE once all acks and all checks are complete. A `read_valid` arriving before its `read_ack` is legal.
- DONE:
  - With `continuous` = 0: hold until `start`, which begins a new pass.
  - With `continuous` = 1: stay one cycle, then re-enter WRITE with the same mode.
  - `pass_count` increments on every DONE entry.
- Ignored inputs:
  - `start` in WRITE or READ.
  - `write_ack` outside WRITE; `read_ack` / `read_valid` outside READ.
  - `read_ack` beyond the `NUM_OF_TEST_DATA`-th.
- `abort` has priority over `start` and over every transition. It goes to IDLE, drops both enables, and keeps the status registers.

## Timing
- Reset values: IDLE; all outputs 0 except `i_user_data_address` = `START_ADDRESS` and `data_to_ram` = word 0 of the incrementing pattern (0).
- `start` at cycle t → `write_enable` = 1 at t+1 with address `START_ADDRESS` and word 0.
- `write_ack` at cycle t → next address/data at t+1. A continuous `write_ack` sustains 1 word per cycle.
- Last `write_ack` at cycle t → at t+1, `write_enable` = 0 and `read_enable` = 1 with address `START_ADDRESS`. No idle gap.
- Compare result is registered: `error_count` updates 1 cycle after `read_valid`.
- The last check at cycle t, with reads already complete → `done` = 1 at t+1. `pass` is valid in the same cycle, because it includes the final compare.
- All outputs are registered; there are no combinational paths from input to output.
- `resetn` low mid-pass clears state immediately (asynchronously). Release is sampled on the next `clk` edge.

## Test plan
- Pattern 0, N=4, ack every cycle, ideal memory echo → data written is 0,1,2,3 at addresses 0–3; `done`=1, `pass`=1, `error_count`=0, `pass_count`=1.
- Pattern 1, seed 1, taps B8, N=4 → write data is 01, B8, 5C, 2E; readback matches and `pass`=1.
- Memory corrupts word 2 (data XOR 0x01) with pattern 2 → `error_count`=1, `first_error_address`=2, `pass`=0.
- Random stall of `write_ack`/`read_ack` (gaps of 0–5 cycles) and `read_valid` delayed 3 cycles → the same results as the zero-stall case; each enable stays asserted through its stall.
- `continuous`=1, N=1 → `pass_count` reaches 3 after three passes; `abort` mid-READ → IDLE next cycle, both enables 0.
- `resetn` pulsed low during WRITE (k=2) → all outputs return to their reset values; a following `start` writes from address 0.

Source files
------------

// File: rtl/ddr3_loopback_tester.sv
// Pattern write/readback tester for the ddr3_memory_controller user port.
// All outputs registered; one word per cycle with continuous acks, and enables hold through stalls.
module ddr3_loopback_tester #(
  parameter int DQ_BITWIDTH = 8,
  parameter int ADDRESS_BITWIDTH = 15,
  parameter int BANK_ADDRESS_BITWIDTH = 3,
  parameter int NUM_OF_TEST_DATA = 4,
  parameter logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] START_ADDRESS = '0,
  parameter logic [DQ_BITWIDTH-1:0] LFSR_TAPS = 8'hB8,
  parameter logic [DQ_BITWIDTH-1:0] LFSR_SEED = {{(DQ_BITWIDTH-1){1'b0}}, 1'b1},
  parameter int ERR_CNT_BITWIDTH = 8
) (
  input  logic                                              clk,
  input  logic                                              resetn,
  input  logic                                              start,
  input  logic                                              abort,
  input  logic [1:0]                                        pattern_sel,
  input  logic                                              continuous,
  output logic                                              write_enable,
  output logic                                              read_enable,
  output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] i_user_data_address,
  output logic [DQ_BITWIDTH-1:0]                            data_to_ram,
  input  logic                                              write_ack,
  input  logic                                              read_ack,
  input  logic                                              read_valid,
  input  logic [DQ_BITWIDTH-1:0]                            data_from_ram,
  output logic                                              busy,
  output logic                                              done,
  output logic                                              pass,
  output logic [ERR_CNT_BITWIDTH-1:0]                       error_count,
  output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] first_error_address,
  output logic [ERR_CNT_BITWIDTH-1:0]                       pass_count
);

  localparam int AW = BANK_ADDRESS_BITWIDTH + ADDRESS_BITWIDTH;
  localparam int CW = $clog2(NUM_OF_TEST_DATA + 1);
  localparam logic [CW-1:0] N_LAST = CW'(NUM_OF_TEST_DATA - 1);
  localparam logic [CW-1:0] N_ALL  = CW'(NUM_OF_TEST_DATA);
  localparam logic [ERR_CNT_BITWIDTH-1:0] ERR_MAX = '1;
  localparam logic [DQ_BITWIDTH-1:0] D_ONE = {{(DQ_BITWIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

  state_t                      r_state, w_state_nxt;
  logic [1:0]                  r_mode;
  logic                        r_cont;
  logic [CW-1:0]               r_wr_cnt, r_rd_cnt, r_chk_cnt;
  logic [AW-1:0]               r_addr, r_first_addr;
  logic [DQ_BITWIDTH-1:0]      r_wgen, r_cgen;
  logic [ERR_CNT_BITWIDTH-1:0] r_err, r_pass_cnt, w_err_nxt;
  logic                        r_err_seen;
  logic                        r_we, r_re, r_busy, r_done, r_pass;
  logic                        w_we_nxt, w_re_nxt, w_busy_nxt, w_done_nxt, w_pass_nxt;
  logic                        w_start_acc, w_wr, w_rd, w_chk, w_mis;
  logic                        w_rd_done, w_chk_done, w_enter_wr;
  logic [1:0]                  w_mode_nxt;

  function automatic logic [DQ_BITWIDTH-1:0] f_word0(input logic [1:0] mode);
    logic [DQ_BITWIDTH-1:0] w;
    w = '0;
    case (mode)
      2'd1:    w = (LFSR_SEED == '0) ? D_ONE : LFSR_SEED;
      2'd2:    w = D_ONE;
      2'd3:    for (int i = 0; i < DQ_BITWIDTH; i++) w[i] = ~i[0];
      default: w = '0;
    endcase
    return w;
  endfunction

  // Each pattern's next word depends only on the current word, so one register per generator suffices.
  function automatic logic [DQ_BITWIDTH-1:0] f_next(input logic [1:0] mode,
                                                     input logic [DQ_BITWIDTH-1:0] d);
    logic [DQ_BITWIDTH-1:0] n;
    case (mode)
      2'd0:    n = d + D_ONE;
      2'd1:    n = (d >> 1) ^ (d[0] ? LFSR_TAPS : '0);
      2'd2:    n = {d[DQ_BITWIDTH-2:0], d[DQ_BITWIDTH-1]};
      default: n = ~d;
    endcase
    return n;
  endfunction

  assign w_start_acc = start && !abort && (r_state == S_IDLE || r_state == S_DONE);
  assign w_wr        = (r_state == S_WRITE) && write_ack && !abort;
  assign w_rd        = (r_state == S_READ) && read_ack && (r_rd_cnt != N_ALL) && !abort;
  assign w_chk       = (r_state == S_READ) && read_valid && (r_chk_cnt != N_ALL) && !abort;
  assign w_mis       = w_chk && (data_from_ram != r_cgen);
  assign w_rd_done   = (r_rd_cnt == N_ALL) || (w_rd && r_rd_cnt == N_LAST);
  assign w_chk_done  = (r_chk_cnt == N_ALL) || (w_chk && r_chk_cnt == N_LAST);
  assign w_err_nxt   = (w_mis && r_err != ERR_MAX) ? r_err + 1'b1 : r_err;
  assign w_enter_wr  = (w_state_nxt == S_WRITE) && (r_state != S_WRITE);
  assign w_mode_nxt  = w_start_acc ? pattern_sel : r_mode;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start) w_state_nxt = S_WRITE;
        S_WRITE: if (w_wr && r_wr_cnt == N_LAST) w_state_nxt = S_READ;
        S_READ:  if (w_rd_done && w_chk_done) w_state_nxt = S_DONE;
        S_DONE:  if (start || r_cont) w_state_nxt = S_WRITE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Output flags are derived from the next state so they can be registered without a cycle of lag.
  always_comb begin
    w_we_nxt   = (w_state_nxt == S_WRITE);
    w_re_nxt   = (w_state_nxt == S_READ) && !(r_state == S_READ && w_rd_done);
    w_busy_nxt = (w_state_nxt == S_WRITE) || (w_state_nxt == S_READ);
    w_done_nxt = (w_state_nxt == S_DONE);
    w_pass_nxt = w_done_nxt && (w_err_nxt == '0);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mode       <= 2'd0;
      r_cont       <= 1'b0;
      r_wr_cnt     <= '0;
      r_rd_cnt     <= '0;
      r_chk_cnt    <= '0;
      r_addr       <= START_ADDRESS;
      r_first_addr <= '0;
      r_wgen       <= '0;
      r_cgen       <= '0;
      r_err        <= '0;
      r_err_seen   <= 1'b0;
      r_pass_cnt   <= '0;
      r_we         <= 1'b0;
      r_re         <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
    end else begin
      r_we   <= w_we_nxt;
      r_re   <= w_re_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      r_pass <= w_pass_nxt;
      if (w_start_acc) begin
        r_mode <= pattern_sel;
        r_cont <= continuous;
      end
      if (w_enter_wr) begin
        r_wr_cnt     <= '0;
        r_rd_cnt     <= '0;
        r_chk_cnt    <= '0;
        r_err        <= '0;
        r_first_addr <= '0;
        r_err_seen   <= 1'b0;
        r_wgen       <= f_word0(w_mode_nxt);
        r_cgen       <= f_word0(w_mode_nxt);
        r_addr       <= START_ADDRESS;
      end else begin
        if (w_wr) begin
          r_wr_cnt <= r_wr_cnt + 1'b1;
          r_wgen   <= f_next(r_mode, r_wgen);
          r_addr   <= (r_wr_cnt == N_LAST) ? START_ADDRESS : r_addr + 1'b1;
        end
        if (w_rd) begin
          r_rd_cnt <= r_rd_cnt + 1'b1;
          r_addr   <= r_addr + 1'b1;
        end
        if (w_chk) begin
          r_chk_cnt <= r_chk_cnt + 1'b1;
          r_cgen    <= f_next(r_mode, r_cgen);
          r_err     <= w_err_nxt;
          if (w_mis && !r_err_seen) begin
            r_first_addr <= START_ADDRESS + AW'(r_chk_cnt);
            r_err_seen   <= 1'b1;
          end
        end
      end
      if (w_state_nxt == S_DONE && r_state != S_DONE) r_pass_cnt <= r_pass_cnt + 1'b1;
    end
  end

  assign write_enable        = r_we;
  assign read_enable         = r_re;
  assign i_user_data_address = r_addr;
  assign data_to_ram         = r_wgen;
  assign busy                = r_busy;
  assign done                = r_done;
  assign pass                = r_pass;
  assign error_count         = r_err;
  assign first_error_address = r_first_addr;
  assign pass_count          = r_pass_cnt;

endmodule
